// File: rtl/dm_sized_pkg.sv
// Shared types for the sized data memory: size codes, FSM states,
// and the load lane-extract/extend helper.
package dm_pkg;

    typedef enum logic [1:0] {
        DM_SZ_B = 2'b00,
        DM_SZ_H = 2'b01,
        DM_SZ_W = 2'b10,
        DM_SZ_R = 2'b11
    } dm_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } dm_state_e;

    localparam int DM_CNT_W = 8;

    function automatic logic [31:0] dm_extract(
        input logic [31:0] w,
        input dm_size_e    sz,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        r = w;
        unique case (1'b1)
            sz == DM_SZ_B: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            sz == DM_SZ_H: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default:       r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_sized_if.sv
// Request/response bundle between the load/store stage and dm_sized.
// master = CPU side, slave = memory side.
interface dm_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size,
        output req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size,
        input  req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_sized_lane.sv
// Combinational lane logic: store byte-enable/merge and load
// lane select with sign or zero extension (little-endian).
module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wword,
    output logic [31:0] rdata
);
    logic [3:0]  be;
    logic [31:0] wpos;

    always_comb begin
        be   = 4'b1111;
        wpos = wdata;
        unique case (1'b1)
            size == DM_SZ_B: begin
                be   = 4'b0001 << off;
                wpos = {4{wdata[7:0]}};
            end
            size == DM_SZ_H: begin
                be   = off[1] ? 4'b1100 : 4'b0011;
                wpos = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        wword = rword;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wword[8*i +: 8] = wpos[8*i +: 8];
        end
    end

    assign rdata = dm_extract(rword, dm_size_e'(size), off, uns);

endmodule

// File: rtl/dm_sized.sv
// Word-organised data RAM with sized loads/stores and wait states.
// Optional DM_MISALIGN_EXC_EN: reject misaligned/reserved accesses.
module dm_sized
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input logic clk,
    input logic rst_n,
    dm_if.slave bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam logic [DM_CNT_W-1:0] WLOAD =
        (WAIT_CYCLES > 0) ? DM_CNT_W'(WAIT_CYCLES - 1)
                          : '0;

    dm_state_e state, nstate;
    logic [DM_CNT_W-1:0] cnt, ncnt;
    logic acc;
    logic idle;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              a_we;
    logic [1:0]        a_size;
    logic              a_uns;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic              a_err;

    logic [31:0] mem [DEPTH];
    logic [31:0] rword;
    logic [31:0] wword;
    logic [31:0] ldata;
    logic [31:0] rdata_q;

    assign idle = (state == ST_IDLE);

    // With no wait states the access edge is the accept edge,
    // so the live request fields feed the RAM directly.
    assign a_we    = idle ? bus.req_we       : r_we;
    assign a_size  = idle ? bus.req_size     : r_size;
    assign a_uns   = idle ? bus.req_unsigned : r_uns;
    assign a_addr  = idle ? bus.req_addr     : r_addr;
    assign a_wdata = idle ? bus.req_wdata    : r_wdata;

`ifdef DM_MISALIGN_EXC_EN
    logic err_q;
    assign a_err = (a_size == DM_SZ_R)
                 | ((a_size == DM_SZ_H) & a_addr[0])
                 | ((a_size == DM_SZ_W) & (a_addr[1:0] != 2'b00));
`else
    assign a_err = 1'b0;
`endif

    always_comb begin
        nstate = state;
        ncnt   = cnt;
        acc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        nstate = ST_DONE;
                        acc    = 1'b1;
                    end else begin
                        nstate = ST_WAIT;
                        ncnt   = WLOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    nstate = ST_DONE;
                    acc    = 1'b1;
                end else begin
                    ncnt = cnt - 1'b1;
                end
            end
            ST_DONE: nstate = ST_IDLE;
            default: nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            rdata_q <= '0;
`ifdef DM_MISALIGN_EXC_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            if (idle && bus.req_valid) begin
                r_we    <= bus.req_we;
                r_size  <= bus.req_size;
                r_uns   <= bus.req_unsigned;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (acc) begin
                rdata_q <= (a_we || a_err) ? 32'h0 : ldata;
`ifdef DM_MISALIGN_EXC_EN
                err_q   <= a_err;
`endif
            end
        end
    end

    assign rword = mem[a_addr[ADDR_W-1:2]];

    // rst_n gate keeps a store from committing while reset is held.
    always_ff @(posedge clk) begin
        if (acc && rst_n && a_we && !a_err) begin
            mem[a_addr[ADDR_W-1:2]] <= wword;
        end
    end

    dm_lane u_lane (
        .size  (a_size),
        .uns   (a_uns),
        .off   (a_addr[1:0]),
        .wdata (a_wdata),
        .rword (rword),
        .wword (wword),
        .rdata (ldata)
    );

    assign bus.req_ready = idle;
    assign bus.rsp_valid = (state == ST_DONE);
    assign bus.rsp_rdata = rdata_q;
`ifdef DM_MISALIGN_EXC_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: doc/dm_sized.md
# dm_sized

Parametrised successor to the 4 KiB data memory. It is a word-organised synchronous data RAM with byte, halfword and word loads and stores, sign or zero extension on loads, and a configurable wait-state counter behind a valid/ready request and response handshake. It sits between the CPU load/store stage and backing storage. The CPU stalls on `req_ready`/`rsp_valid`, so the multi-cycle memory timing of later generations can be modelled without changing the core.

## Interface
- `ADDR_W`, 12, byte-address width; storage is 2**(ADDR_W-2) 32-bit words.
- `WAIT_CYCLES`, 0, extra cycles inserted between accept and response (0..255).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores and word loads.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  one-cycle completion pulse (loads and stores).
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  access rejected (see Configuration); valid with `rsp_valid`.

## Operation
- State machine: IDLE, WAIT, DONE.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, wait counter 0. RAM contents are not reset.
- IDLE: `req_ready`=1. On `req_valid`, latch `we`, `size`, `unsigned`, `addr` and `wdata`.
  - If WAIT_CYCLES=0, go to DONE.
  - Otherwise go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: `req_ready`=0. Decrement the counter each cycle. Go to DONE on the edge where the counter is 0.
- Memory access happens on the edge entering DONE.
  - Store: write only the lanes selected by the latched address and size. Other lanes are unchanged.
  - Load: read the word, select the lane, extend it, and register the result into `rsp_rdata`.
- DONE: `rsp_valid`=1 and `req_ready`=0. Always return to IDLE next edge. No response backpressure.
- Lane mapping is little-endian.
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
  - Word index = addr[ADDR_W-1:2].
- Reserved size 11 behaves as word.
- `rsp_rdata` and `rsp_err` hold their values until the next DONE. `rsp_rdata` is 0 after a store.
- Reset mid-operation: state returns to IDLE immediately. An uncommitted store, one still in IDLE accept or WAIT, is discarded and RAM is unchanged.

## Timing
- Accept edge to `rsp_valid` high: WAIT_CYCLES+1 cycles.
- Back-to-back throughput: one request per WAIT_CYCLES+2 cycles.
- `req_ready` is registered-state decoded, with no combinational path from `req_valid`.
- Load data is visible in the same cycle as `rsp_valid`.
- A load issued after a store to the same word observes the stored data.

## Configuration
- `DM_MISALIGN_EXC_EN` defined:
  - A half access with addr[0]=1, a word access with addr[1:0]≠0, or size 11 completes normally in timing.
  - No RAM write takes place, `rsp_rdata`=0 and `rsp_err`=1.
- `DM_MISALIGN_EXC_EN` undefined:
  - Low address bits below the access size are ignored: half uses addr[1], word ignores addr[1:0].
  - `rsp_err` is tied 0.

## Structure
- Shared package `dm_pkg`: size encodings (`DM_SZ_B`, `DM_SZ_H`, `DM_SZ_W`), FSM state enum, and a lane-extract/extend function.
- One natural sub-module, `dm_lane`. It is combinational and performs store byte-enable and merge generation plus load lane select and extension. The FSM, counter and RAM array stay in `dm_sized`.

## Test plan
- Word store 0x80FF1046 at 0x000, then:
  - lw 0x000 returns 0x80FF1046.
  - lb 0x002 returns 0xFFFFFFFF.
  - lbu 0x002 returns 0x000000FF.
  - lh 0x002 returns 0xFFFF80FF.
  - lhu 0x000 returns 0x00001046.
- sb 0x00000012 at 0x001 after the above, then lw 0x000 returns 0x80FF1246. Sh 0xABCD at 0x002, then lw returns 0xABCD1246.
- WAIT_CYCLES=3: accept at cycle t gives `rsp_valid` exactly at t+4 for one cycle. `req_ready` is low t+1..t+4 and high t+5.
- WAIT_CYCLES=3: store 0xDEADBEEF to 0x004, with `rst_n` pulsed low in WAIT. A later lw 0x004 returns the prior value, and `rsp_valid` never pulses for the aborted store.
- With `DM_MISALIGN_EXC_EN`: lw 0x002 gives `rsp_err`=1 and `rsp_rdata`=0. A sw to 0x006 leaves word 1 unchanged. Without the macro, lw 0x002 returns word 0.
- Reset check: immediately after `rst_n` deasserts, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0 and `rsp_err`=0.
